// File: rtl/fact_pkg.sv
// Shared types and widths for the factorial accelerator: FSM state, control bundle, decode helper.
package fact_pkg;

  localparam int unsigned FACT_N_MAX = 12;
  localparam int unsigned FACT_N_W   = 4;
  localparam int unsigned FACT_OUT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_MUL   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } fact_state_t;

  typedef struct packed {
    logic sel1;
    logic sel2;
    logic reg_load;
    logic cnt_load;
    logic cnt_en;
    logic done;
    logic err;
    logic busy;
  } fact_ctrl_t;

  // Moore output decode for a given state; unused encodings decode to all-zero.
  function automatic fact_ctrl_t fact_decode(input fact_state_t st);
    fact_ctrl_t c;
    c = '0;
    case (st)
      S_LOAD: begin
        c.cnt_load = 1'b1;
        c.reg_load = 1'b1;
        c.busy     = 1'b1;
      end
      S_CHECK: c.busy = 1'b1;
      S_MUL: begin
        c.sel1     = 1'b1;
        c.reg_load = 1'b1;
        c.cnt_en   = 1'b1;
        c.busy     = 1'b1;
      end
      S_DONE: begin
        c.sel2 = 1'b1;
        c.done = 1'b1;
      end
      S_ERROR: begin
        c.done = 1'b1;
        c.err  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fact_cu.sv
// Factorial datapath control unit: Moore FSM with four-phase go/done handshake.
// Optional FACT_CU_ABORT_EN adds an abort input that cancels a running computation.
module fact_cu
  import fact_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic go,
`ifdef FACT_CU_ABORT_EN
  input  logic abort,
`endif
  input  logic GT_flag,
  input  logic Err,
  output logic sel1,
  output logic sel2,
  output logic reg_load,
  output logic cnt_load,
  output logic cnt_en,
  output logic done,
  output logic err,
  output logic busy
);

  fact_state_t state;
  fact_state_t state_next;
  fact_ctrl_t  ctrl;

  // Outputs are flopped from the next-state decode so they track the state register exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ctrl  <= '0;
    end else begin
      state <= state_next;
      ctrl  <= fact_decode(state_next);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (go) state_next = Err ? S_ERROR : S_LOAD;
      S_LOAD:  state_next = S_CHECK;
      S_CHECK: state_next = GT_flag ? S_MUL : S_DONE;
      S_MUL:   state_next = S_CHECK;
      S_DONE:  if (!go) state_next = S_IDLE;
      S_ERROR: if (!go) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
`ifdef FACT_CU_ABORT_EN
    // Abort overrides every other transition, but only while busy.
    if (abort && (state == S_LOAD || state == S_CHECK || state == S_MUL))
      state_next = S_IDLE;
`endif
  end

  assign sel1     = ctrl.sel1;
  assign sel2     = ctrl.sel2;
  assign reg_load = ctrl.reg_load;
  assign cnt_load = ctrl.cnt_load;
  assign cnt_en   = ctrl.cnt_en;
  assign done     = ctrl.done;
  assign err      = ctrl.err;
  assign busy     = ctrl.busy;

endmodule

// File: tb/tb_fact_cu.sv
// Integration bench: fact_cu driving a small factorial datapath, checked against plain arithmetic.
module tb_fact_cu;
  import fact_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic go;
  logic abort;
  logic GT_flag;
  logic Err;
  logic sel1, sel2, reg_load, cnt_load, cnt_en, done, err, busy;

  logic [FACT_N_W-1:0]   n   = '0;
  logic [FACT_N_W-1:0]   cnt = '0;
  logic [FACT_OUT_W-1:0] acc = '0;
  logic [FACT_OUT_W-1:0] out_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fact_cu dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
`ifdef FACT_CU_ABORT_EN
    .abort    (abort),
`endif
    .GT_flag  (GT_flag),
    .Err      (Err),
    .sel1     (sel1),
    .sel2     (sel2),
    .reg_load (reg_load),
    .cnt_load (cnt_load),
    .cnt_en   (cnt_en),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  // Datapath: down-counter, result register, output gate.
  always_ff @(posedge clk) begin
    if (cnt_load)    cnt <= n;
    else if (cnt_en) cnt <= cnt - 4'd1;
    if (reg_load)    acc <= sel1 ? acc * 32'(cnt) : 32'd1;
  end
  assign GT_flag = (cnt > 4'd1);
  assign Err     = (32'(n) > FACT_N_MAX);
  assign out_val = sel2 ? acc : 32'd0;

  function automatic longint ref_out(input int nv);
    longint r = 1;
    if (nv > 12) return 0;
    for (int i = 2; i <= nv; i++) r = r * i;
    return r;
  endfunction

  function automatic int ref_cycle(input int nv);
    if (nv > 12) return 1;
    return (nv < 2) ? 3 : 2 * nv + 1;
  endfunction

  // One complete handshake: start with go, wait for done, hold, release.
  task automatic run_job(input int nv, input int hold, input bit scramble_n);
    int  cyc = 0;
    bit  seen = 0;
    bit  busy_bad = 0;
    bit  loads = 0;
    bit  hold_bad = 0;
    @(negedge clk);
    n  = 4'(nv);
    go = 1'b1;
    @(posedge clk);
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (reg_load || cnt_load) loads = 1;
      if (done) seen = 1;
      else if (busy !== 1'b1) busy_bad = 1;
      if (scramble_n && cyc == 2) n = 4'($urandom_range(0, 15));
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout n=%0d: no done within %0d cycles", nv, cyc);
      go = 1'b0;
      return;
    end
    total++;
    if (cyc != ref_cycle(nv)) begin
      bad++; $display("FAIL done_cycle n=%0d: got %0d want %0d", nv, cyc, ref_cycle(nv));
    end
    total++;
    if (64'(out_val) !== ref_out(nv)) begin
      bad++; $display("FAIL out n=%0d: got %0d want %0d", nv, out_val, ref_out(nv));
    end
    total++;
    if (err !== (nv > 12)) begin
      bad++; $display("FAIL err n=%0d: got %b want %b", nv, err, (nv > 12));
    end
    total++;
    if (busy_bad || busy !== 1'b0) begin
      bad++; $display("FAIL busy n=%0d: busy wrong before/at done (busy=%b)", nv, busy);
    end
    total++;
    if (loads !== (nv <= 12)) begin
      bad++; $display("FAIL loads n=%0d: got %b want %b", nv, loads, (nv <= 12));
    end
    repeat (hold) begin
      @(negedge clk);
      if (done !== 1'b1 || 64'(out_val) !== ref_out(nv)) hold_bad = 1;
    end
    total++;
    if (hold_bad) begin
      bad++; $display("FAIL hold n=%0d: done/out not stable while go high", nv);
    end
    go = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL release n=%0d: done=%b err=%b busy=%b want 000", nv, done, err, busy);
    end
  endtask

  task automatic test_reset();
    bit idle_bad = 0;
    go = 1'b0; abort = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({sel1, sel2, reg_load, cnt_load, cnt_en, done, err, busy} !== 8'h00) begin
      bad++; $display("FAIL reset_outputs: got %b want 00000000",
                      {sel1, sel2, reg_load, cnt_load, cnt_en, done, err, busy});
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if ({sel1, sel2, reg_load, cnt_load, cnt_en, done, err, busy} !== 8'h00) idle_bad = 1;
    end
    total++;
    if (idle_bad) begin
      bad++; $display("FAIL idle_quiet: outputs active with go low");
    end
  endtask

  task automatic test_directed();
    run_job(5, 0, 0);
    run_job(0, 0, 0);
    run_job(1, 0, 0);
    run_job(12, 5, 0);
    run_job(13, 2, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++)
      run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    @(negedge clk);
    n = 4'd6; go = 1'b1;
    while (cnt_en !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (cnt_en !== 1'b1) begin
      bad++; $display("FAIL mul_reach: cnt_en never asserted for n=6");
    end
    reset = 1'b1;
    go    = 1'b0;
    #1;
    total++;
    if ({sel1, sel2, reg_load, cnt_load, cnt_en, done, err, busy} !== 8'h00) begin
      bad++; $display("FAIL mid_reset: got %b want 00000000",
                      {sel1, sel2, reg_load, cnt_load, cnt_en, done, err, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_job(3, 0, 0);
  endtask

`ifdef FACT_CU_ABORT_EN
  task automatic test_abort();
    bit done_seen = 0;
    @(negedge clk);
    n = 4'd7; go = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_idle: busy=%b done=%b want 00", busy, done);
    end
    go = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    total++;
    if (done_seen) begin
      bad++; $display("FAIL abort_done: done rose after abort");
    end
    run_job(4, 0, 0);
  endtask
`endif

  initial begin
    reset = 1'b1; go = 1'b0; abort = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_mid_reset();
`ifdef FACT_CU_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
